// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU control/op codes, FSM states and datapath select encodings.
// Imported by the controller top and its ALU decoder.
package mips_multicycle_control_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    // FSM states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PCSrc selects
    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ALU decoder: maps ALUOp and funct to the 3-bit ALUControl code.
// Latency: purely combinational. Backpressure: none.
// Ports: alu_op (from FSM), funct (instr[5:0]) -> alu_control (to ALU).
module mips_multicycle_control_alu_decoder
    import mips_multicycle_control_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  aluop_t             alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [2:0]         alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    // Unsupported funct quietly falls back to add.
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS controller: Moore FSM plus output decode driving ALU selects and datapath strobes.
// Latency: outputs combinational from state (+Zero, mem_ready); one state step per clock.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold while mem_ready=0 with their strobes low.
// Ports: clk, rst_n (sync, active-low); Op/Funct from IR; Zero from ALU; mem_ready from memory;
//        ALU selects/control, PC/memory/regfile controls, illegal_op pulse, debug state.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    Op,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic [2:0]         ALUControl,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               PCEn,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t cur;
    aluop_t alu_op;
    logic   pc_write;
    logic   branch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur <= S_FETCH;
        end else begin
            case (cur)
                S_FETCH:    if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_RTYPE:     cur <= S_EXEC_R;
                        OP_BEQ:       cur <= S_BEQ;
                        OP_ADDI:      cur <= S_ADDI_EX;
                        OP_J:         cur <= S_JUMP;
                        default:      cur <= S_FETCH;
                    endcase
                end
                // IR still holds the instruction, so Op picks load vs store here.
                S_MEMADR:   cur <= (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) cur <= S_MEMWB;
                S_MEMWB:    cur <= S_FETCH;
                S_MEMWRITE: if (mem_ready) cur <= S_FETCH;
                S_EXEC_R:   cur <= S_ALUWB;
                S_ALUWB:    cur <= S_FETCH;
                S_BEQ:      cur <= S_FETCH;
                S_ADDI_EX:  cur <= S_ADDI_WB;
                S_ADDI_WB:  cur <= S_FETCH;
                S_JUMP:     cur <= S_FETCH;
                default:    cur <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        alu_op     = ALUOP_ADD;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        PCSrc      = PCSRC_ALURES;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        case (cur)
            S_FETCH: begin
                ALUSrcB  = SRCB_FOUR;
                IRWrite  = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut while decoding.
                ALUSrcB = SRCB_IMMSH2;
                case (Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default: illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = mem_ready;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDI_WB:  RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc    = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase

        PCEn = pc_write | (branch & Zero);

        // Reset masks every strobe immediately, so a reset landing mid-instruction
        // never leaks a write in the cycle it is asserted.
        if (!rst_n) begin
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            PCEn       = 1'b0;
            illegal_op = 1'b0;
        end
    end

    mips_multicycle_control_alu_decoder #(
        .FUNCT_W(FUNCT_W)
    ) u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (ALUControl)
    );

    assign state = cur;

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;
    import mips_multicycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCEn, illegal_op;
    logic [3:0] state;

    int total  = 0;
    int passed = 0;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCEn(PCEn), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, total=%0d passed=%0d", total, passed);
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       iord, mw, irw, rd, m2r, rw, pcen, ill;
    } exp_t;

    function automatic logic known_op(input logic [5:0] op);
        return op == OP_LW || op == OP_SW || op == OP_RTYPE || op == OP_BEQ ||
               op == OP_ADDI || op == OP_J;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs for one cycle spent in state s, from the per-state rules.
    function automatic exp_t model(input state_t s, input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input logic rdy, input logic rn);
        exp_t e;
        e     = '0;
        e.st  = s;
        e.alu = 3'b010;
        case (s)
            S_FETCH:    begin e.srcb = 2'b01; e.irw = rdy; e.pcen = rdy; end
            S_DECODE:   begin e.srcb = 2'b11; e.ill = !known_op(op); end
            S_MEMADR:   begin e.srca = 1'b1; e.srcb = 2'b10; end
            S_MEMREAD:  e.iord = 1'b1;
            S_MEMWB:    begin e.m2r = 1'b1; e.rw = 1'b1; end
            S_MEMWRITE: begin e.iord = 1'b1; e.mw = rdy; end
            S_EXEC_R:   begin e.srca = 1'b1; e.alu = funct_alu(fn); end
            S_ALUWB:    begin e.rd = 1'b1; e.rw = 1'b1; end
            S_BEQ:      begin e.srca = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
            S_ADDI_EX:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            S_ADDI_WB:  e.rw = 1'b1;
            S_JUMP:     begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: ;
        endcase
        if (!rn) begin
            e.mw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.pcen = 1'b0; e.ill = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive inputs on the falling edge, check just after.
    task automatic step(input state_t s, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input logic z, input logic rn);
        exp_t  e;
        string n;
        @(negedge clk);
        Op = op; Funct = fn; mem_ready = rdy; Zero = z; rst_n = rn;
        #1;
        e = model(s, op, fn, z, rdy, rn);
        n = s.name();
        chk({n, ".state"},      32'(state),      32'(e.st));
        chk({n, ".ALUControl"}, 32'(ALUControl), 32'(e.alu));
        chk({n, ".ALUSrcA"},    32'(ALUSrcA),    32'(e.srca));
        chk({n, ".ALUSrcB"},    32'(ALUSrcB),    32'(e.srcb));
        chk({n, ".PCSrc"},      32'(PCSrc),      32'(e.pcsrc));
        chk({n, ".IorD"},       32'(IorD),       32'(e.iord));
        chk({n, ".MemWrite"},   32'(MemWrite),   32'(e.mw));
        chk({n, ".IRWrite"},    32'(IRWrite),    32'(e.irw));
        chk({n, ".RegDst"},     32'(RegDst),     32'(e.rd));
        chk({n, ".MemtoReg"},   32'(MemtoReg),   32'(e.m2r));
        chk({n, ".RegWrite"},   32'(RegWrite),   32'(e.rw));
        chk({n, ".PCEn"},       32'(PCEn),       32'(e.pcen));
        chk({n, ".illegal_op"}, 32'(illegal_op), 32'(e.ill));
        chk({n, ".strobe_onehot"}, 32'($countones({MemWrite, IRWrite, RegWrite}) <= 1), 32'd1);
    endtask

    // Full instruction: wf fetch stalls, wm memory stalls, z drives Zero in BEQ.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input logic z);
        for (int i = 0; i < wf; i++) step(S_FETCH, op, fn, 1'b0, rb(), 1'b1);
        step(S_FETCH, op, fn, 1'b1, rb(), 1'b1);
        step(S_DECODE, op, fn, rb(), rb(), 1'b1);
        if (op == OP_LW || op == OP_SW) begin
            step(S_MEMADR, op, fn, rb(), rb(), 1'b1);
            if (op == OP_LW) begin
                for (int i = 0; i < wm; i++) step(S_MEMREAD, op, fn, 1'b0, rb(), 1'b1);
                step(S_MEMREAD, op, fn, 1'b1, rb(), 1'b1);
                step(S_MEMWB, op, fn, rb(), rb(), 1'b1);
            end else begin
                for (int i = 0; i < wm; i++) step(S_MEMWRITE, op, fn, 1'b0, rb(), 1'b1);
                step(S_MEMWRITE, op, fn, 1'b1, rb(), 1'b1);
            end
        end else if (op == OP_RTYPE) begin
            step(S_EXEC_R, op, fn, rb(), rb(), 1'b1);
            step(S_ALUWB, op, fn, rb(), rb(), 1'b1);
        end else if (op == OP_BEQ) begin
            step(S_BEQ, op, fn, rb(), z, 1'b1);
        end else if (op == OP_ADDI) begin
            step(S_ADDI_EX, op, fn, rb(), rb(), 1'b1);
            step(S_ADDI_WB, op, fn, rb(), rb(), 1'b1);
        end else if (op == OP_J) begin
            step(S_JUMP, op, fn, rb(), rb(), 1'b1);
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         k;

        // Reset held with Op=lw; strobes must stay low even with mem_ready=1.
        rst_n = 1'b0; Op = OP_LW; mem_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        step(S_FETCH, OP_LW, 6'd0, 1'b1, 1'b0, 1'b0);

        // First cycle after release fetches (IRWrite=PCEn=1).
        run_instr(OP_LW, 6'd0, 0, 2, 1'b0);       // lw with two MEMREAD stalls
        run_instr(OP_RTYPE, FUNCT_ADD, 0, 0, 1'b0);
        run_instr(OP_RTYPE, FUNCT_SLT, 0, 0, 1'b0);
        run_instr(OP_BEQ, 6'd0, 0, 0, 1'b1);
        run_instr(OP_BEQ, 6'd0, 0, 0, 1'b0);
        run_instr(6'b111111, 6'd0, 0, 0, 1'b0);   // illegal opcode
        run_instr(OP_ADDI, 6'd0, 1, 0, 1'b0);
        run_instr(OP_J, 6'd0, 0, 0, 1'b0);
        run_instr(OP_SW, 6'd0, 0, 1, 1'b0);

        // sw interrupted by reset while stalled in MEMWRITE: no write pulse.
        step(S_FETCH, OP_SW, 6'd0, 1'b1, 1'b0, 1'b1);
        step(S_DECODE, OP_SW, 6'd0, 1'b1, 1'b0, 1'b1);
        step(S_MEMADR, OP_SW, 6'd0, 1'b1, 1'b0, 1'b1);
        step(S_MEMWRITE, OP_SW, 6'd0, 1'b0, 1'b0, 1'b0);
        step(S_FETCH, OP_SW, 6'd0, 1'b1, 1'b0, 1'b0);

        // R-type interrupted by reset in its writeback cycle.
        run_instr(OP_ADDI, 6'd0, 0, 0, 1'b0);
        step(S_FETCH, OP_RTYPE, FUNCT_OR, 1'b1, 1'b0, 1'b1);
        step(S_DECODE, OP_RTYPE, FUNCT_OR, 1'b1, 1'b0, 1'b1);
        step(S_EXEC_R, OP_RTYPE, FUNCT_OR, 1'b1, 1'b0, 1'b1);
        step(S_ALUWB, OP_RTYPE, FUNCT_OR, 1'b1, 1'b0, 1'b0);
        step(S_FETCH, OP_RTYPE, FUNCT_OR, 1'b1, 1'b0, 1'b0);

        // Randomized instruction stream.
        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: op = OP_RTYPE;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_ADDI;
                5: op = OP_J;
                default: begin
                    op = 6'($urandom);
                    while (known_op(op)) op = 6'($urandom);
                end
            endcase
            k = $urandom_range(0, 6);
            case (k)
                0: fn = FUNCT_ADD;
                1: fn = FUNCT_SUB;
                2: fn = FUNCT_AND;
                3: fn = FUNCT_OR;
                4: fn = FUNCT_SLT;
                default: fn = 6'($urandom);
            endcase
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), rb());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
